divider_sequencer: RTL
======================

# divider_sequencer

Multi-cycle integer divider for the RV32M DIV/DIVU/REM/REMU instructions. It sits directly upstream of the existing ArithmeticUnit and drives its OP/A/B inputs. It issues one restoring-division subtract per cycle and reads back Y and CF. The result goes to the execute-stage writeback mux through a valid/ready handshake.

## Interface
- width, 32, operand and result width in bits (≥ 4)
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  synchronous reset, active-high
- in_valid  input  1  request present
- in_ready  output  1  divider idle and able to accept a request
- op  input  2  00 DIV, 01 DIVU, 10 REM, 11 REMU (funct3[1:0])
- dividend  input  width  rs1 value
- divisor  input  width  rs2 value
- out_valid  output  1  result held and valid
- out_ready  input  1  consumer takes the result
- result  output  width  quotient (DIV/DIVU) or remainder (REM/REMU)
- div_zero  output  1  divisor was zero for the current result

## Operation
- FSM states: IDLE, PREP, ITER, FIX, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid: latch op/dividend/divisor and go to PREP.
- PREP:
  - Signed ops: take magnitudes of both operands and record the sign of each.
  - Divisor==0: result = all-ones for quotient ops, dividend for remainder ops; div_zero=1; go to DONE.
  - Signed overflow (dividend=100…0, divisor=all-ones): quotient=dividend, remainder=0; go to DONE.
  - Otherwise: Q=|dividend|, R=0, count=width-1; go to ITER.
- ITER, one step per cycle:
  - Form partial = {R[width-2:0], Q[width-1]} and carry bit c = R[width-1].
  - Drive ArithmeticUnit with OP=1, A=partial, B=|divisor|.
  - Success when c=1 or CF=0.
  - On success: R←Y, Q←{Q[width-2:0],1}. Else: R←partial, Q←{Q[width-2:0],0}.
  - At count==0 go to FIX; otherwise decrement count.
- FIX:
  - DIV: negate Q if operand signs differ (ArithmeticUnit OP=1, A=0, B=Q).
  - REM: negate R if dividend was negative.
  - Unsigned ops pass through.
  - Go to DONE.
- DONE: out_valid=1, result stable. On out_ready, go to IDLE.
- Backpressure: DONE holds indefinitely. in_ready=0 in every state other than IDLE, so there is always at least one bubble cycle between results.
- ArithmeticUnit inputs are don't-care in IDLE/PREP/DONE. They are driven to 0 in those states to avoid toggling.

## Timing
- in_ready is combinational from state (state==IDLE). All other outputs are registered.
- Accept at edge t, normal path:
  - PREP at t+1.
  - ITER from t+2 to t+width+1.
  - FIX at t+width+2.
  - out_valid at t+width+3 (35 cycles for width=32).
- Divide-by-zero and signed-overflow paths: out_valid at t+2.
- Reset values: state=IDLE, out_valid=0, result=0, div_zero=0, in_ready=1 from the first cycle after rst deasserts.
- rst asserted in any state, including mid-ITER or in DONE with out_ready=0: in-flight request discarded, no result produced, outputs take reset values on the next edge.
- in_valid and out_ready are both sampled only in their owning states. in_valid is ignored outside IDLE.

## Configuration
- DIVIDER_SIGNED_EN defined:
  - DIV/REM execute with sign handling and the overflow short-circuit described above.
- DIVIDER_SIGNED_EN undefined:
  - op[0] is ignored; 00 executes as DIVU and 10 as REMU.
  - No sign logic and no overflow check.
  - FIX is a one-cycle pass-through, so latency is identical in both builds.

## Structure
- Shared package divider_pkg holds:
  - the op encodings DIV_OP_DIV/DIVU/REM/REMU;
  - the FSM state enum;
  - the constant DIV_ZERO_QUOTIENT (all-ones).
- One sub-module: the existing ArithmeticUnit, instantiated with the same width. It is the divider's only adder/subtractor.
- Counter width is $clog2(width).

## Test plan
- DIVU 100/7 → result 14 at t+35. REMU 100/7 → 2. div_zero=0.
- DIV −7/2 (0xFFFFFFF9, 2) → 0xFFFFFFFD (−3). REM → 0xFFFFFFFF (−1). With DIVIDER_SIGNED_EN undefined, the same DIV returns 0x7FFFFFFC.
- DIVU 0xFFFFFFFF/1 → 0xFFFFFFFF. REMU 0xFFFFFFFF/0x80000000 → 0x7FFFFFFF (exercises the carry bit c).
- Divide by zero: DIV 5/0 → 0xFFFFFFFF with div_zero=1 at t+2. REM 5/0 → 5. DIV 0x80000000/0xFFFFFFFF → 0x80000000. REM of the same → 0, at t+2.
- Backpressure: hold out_ready=0 for 10 cycles in DONE → result stable, in_ready=0, new in_valid ignored. Raise out_ready → IDLE next cycle.
- Reset mid-operation: assert rst at t+10 of a DIVU → out_valid=0, in_ready=1 after release. A following DIVU 9/3 returns 3 with normal latency.

Source files
------------

// File: rtl/divider_pkg.sv
// Shared definitions for the divider sequencer: op encodings, FSM states and
// the divide-by-zero quotient constant.
package divider_pkg;

  localparam logic [1:0] DIV_OP_DIV  = 2'b00;
  localparam logic [1:0] DIV_OP_DIVU = 2'b01;
  localparam logic [1:0] DIV_OP_REM  = 2'b10;
  localparam logic [1:0] DIV_OP_REMU = 2'b11;

  // Wide enough for any supported width; users take the low bits.
  localparam logic [63:0] DIV_ZERO_QUOTIENT = '1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREP,
    ST_ITER,
    ST_FIX,
    ST_DONE
  } div_state_t;

endpackage

// File: rtl/divider_sequencer_alu.sv
// ArithmeticUnit: width-bit adder/subtractor. OP=0 adds (CF=carry out),
// OP=1 subtracts A-B (CF=borrow, set when A<B unsigned).
module ArithmeticUnit #(
  parameter int unsigned width = 32
) (
  input  logic             OP,
  input  logic [width-1:0] A,
  input  logic [width-1:0] B,
  output logic [width-1:0] Y,
  output logic             CF
);

  logic [width:0] sum;

  always_comb begin
    if (OP) begin
      sum = {1'b0, A} - {1'b0, B};
    end else begin
      sum = {1'b0, A} + {1'b0, B};
    end
  end

  assign Y  = sum[width-1:0];
  assign CF = sum[width];

endmodule

// File: rtl/divider_sequencer.sv
// Multi-cycle restoring divider for RV32M DIV/DIVU/REM/REMU, one subtract per
// cycle through ArithmeticUnit. Define DIVIDER_SIGNED_EN for signed DIV/REM.
module divider_sequencer
  import divider_pkg::*;
#(
  parameter int unsigned width = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [width-1:0] dividend,
  input  logic [width-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [width-1:0] result,
  output logic             div_zero
);

  localparam int unsigned CW = $clog2(width);

  div_state_t state, state_nxt;

  logic             rem_r;
  logic [width-1:0] dvd_r, dvs_r, q_r, r_r;
  logic [CW-1:0]    count;
  logic             neg_q, neg_r;

  logic             au_op;
  logic [width-1:0] au_a, au_b, au_y;
  logic             au_cf;

  logic [width-1:0] partial;
  logic             carry, step_ok;
  logic             dvd_neg, dvs_neg, dvs_zero, ovf;
  logic [width-1:0] dvd_mag, dvs_mag, fix_val;

  ArithmeticUnit #(.width(width)) u_alu (
    .OP (au_op),
    .A  (au_a),
    .B  (au_b),
    .Y  (au_y),
    .CF (au_cf)
  );

`ifdef DIVIDER_SIGNED_EN
  localparam logic [width-1:0] MIN_INT = {1'b1, {(width-1){1'b0}}};
  logic signed_r;
  assign dvd_neg = signed_r & dvd_r[width-1];
  assign dvs_neg = signed_r & dvs_r[width-1];
  assign ovf     = signed_r && (dvd_r == MIN_INT) && (dvs_r == '1);
`else
  assign dvd_neg = 1'b0;
  assign dvs_neg = 1'b0;
  assign ovf     = 1'b0;
`endif

  assign dvd_mag  = dvd_neg ? ('0 - dvd_r) : dvd_r;
  assign dvs_mag  = dvs_neg ? ('0 - dvs_r) : dvs_r;
  assign dvs_zero = (dvs_r == '0);

  // Shift-in of the next dividend bit; the bit shifted out of R acts as the
  // 33rd bit of the partial remainder, so a set carry always means success.
  assign partial = {r_r[width-2:0], q_r[width-1]};
  assign carry   = r_r[width-1];
  assign step_ok = carry | ~au_cf;
  assign fix_val = (rem_r ? neg_r : neg_q) ? au_y : au_b;

  assign in_ready = (state == ST_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    au_op     = 1'b0;
    au_a      = '0;
    au_b      = '0;
    case (state)
      ST_IDLE: if (in_valid) state_nxt = ST_PREP;
      ST_PREP: state_nxt = (dvs_zero || ovf) ? ST_DONE : ST_ITER;
      ST_ITER: begin
        au_op = 1'b1;
        au_a  = partial;
        au_b  = dvs_r;
        if (count == '0) state_nxt = ST_FIX;
      end
      ST_FIX: begin
        au_op     = 1'b1;
        au_b      = rem_r ? r_r : q_r;
        state_nxt = ST_DONE;
      end
      ST_DONE: if (out_ready) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rem_r     <= 1'b0;
      dvd_r     <= '0;
      dvs_r     <= '0;
      q_r       <= '0;
      r_r       <= '0;
      count     <= '0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      out_valid <= 1'b0;
      result    <= '0;
      div_zero  <= 1'b0;
`ifdef DIVIDER_SIGNED_EN
      signed_r  <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            rem_r    <= (op == DIV_OP_REM) || (op == DIV_OP_REMU);
            dvd_r    <= dividend;
            dvs_r    <= divisor;
`ifdef DIVIDER_SIGNED_EN
            signed_r <= (op == DIV_OP_DIV) || (op == DIV_OP_REM);
`endif
          end
        end
        ST_PREP: begin
          neg_q <= dvd_neg ^ dvs_neg;
          neg_r <= dvd_neg;
          dvs_r <= dvs_mag;
          q_r   <= dvd_mag;
          r_r   <= '0;
          count <= CW'(width - 1);
          if (dvs_zero) begin
            result    <= rem_r ? dvd_r : DIV_ZERO_QUOTIENT[width-1:0];
            div_zero  <= 1'b1;
            out_valid <= 1'b1;
          end else if (ovf) begin
            result    <= rem_r ? '0 : dvd_r;
            div_zero  <= 1'b0;
            out_valid <= 1'b1;
          end
        end
        ST_ITER: begin
          q_r   <= {q_r[width-2:0], step_ok};
          r_r   <= step_ok ? au_y : partial;
          count <= count - CW'(1);
        end
        ST_FIX: begin
          result    <= fix_val;
          div_zero  <= 1'b0;
          out_valid <= 1'b1;
        end
        ST_DONE: if (out_ready) out_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule
